// File: rtl/scpu_pkg.sv
// Shared scpu definitions: pipeline sequencer states and fixed encodings.
package scpu_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StFlush   = 2'd1,
    StMemWait = 2'd2
  } ctrl_state_e;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [4:0]  REG_X0   = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for pipeline performance visibility.
module sat_counter #(
  parameter int unsigned Width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (inc && (count_q != {Width{1'b1}})) begin
      count_q <= count_q + Width'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: stall/flush/bubble generation for load-use,
// EX redirects and data-memory waits, plus stall/flush performance counters.
module pipe_hazard_ctrl
  import scpu_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_mem_read,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_bubble,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  localparam logic [2:0] FlushLoad = 3'(FLUSH_CYCLES - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       load_use;
  logic       mem_wait;
  logic       run_rules;

  assign load_use = ex_mem_read && (ex_rd_addr != REG_X0) &&
                    ((id_use_rs1 && (ex_rd_addr == id_rs1_addr)) ||
                     (id_use_rs2 && (ex_rd_addr == id_rs2_addr)));
  assign mem_wait = mem_req && !mem_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    run_rules    = 1'b0;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_stall   = 1'b0;
    idex_flush   = 1'b0;
    exmem_stall  = 1'b0;
    memwb_bubble = 1'b0;

    case (state_q)
      StFlush: begin
        // A redirect here can only be spurious (EX holds a bubble), so it is ignored.
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (mem_wait) begin
          exmem_stall  = 1'b1;
          memwb_bubble = 1'b1;
        end else if (cnt_q <= 3'd1) begin
          cnt_d   = 3'd0;
          state_d = StRun;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StMemWait: begin
        if (!mem_ready) begin
          pc_stall     = 1'b1;
          ifid_stall   = 1'b1;
          idex_stall   = 1'b1;
          exmem_stall  = 1'b1;
          memwb_bubble = 1'b1;
        end else begin
          run_rules = 1'b1;
        end
      end
      default: run_rules = 1'b1;
    endcase

    // The MEM_WAIT release cycle shares RUN arbitration so a held redirect fires once.
    if (run_rules) begin
      state_d = StRun;
      if (mem_wait) begin
        pc_stall     = 1'b1;
        ifid_stall   = 1'b1;
        idex_stall   = 1'b1;
        exmem_stall  = 1'b1;
        memwb_bubble = 1'b1;
        state_d      = StMemWait;
      end else if (ex_redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          cnt_d   = FlushLoad;
          state_d = StFlush;
        end
      end else if (load_use) begin
        pc_stall   = 1'b1;
        ifid_stall = 1'b1;
        idex_flush = 1'b1;
      end
    end

    if (rst) begin
      pc_stall     = 1'b0;
      ifid_stall   = 1'b0;
      ifid_flush   = 1'b0;
      idex_stall   = 1'b0;
      idex_flush   = 1'b0;
      exmem_stall  = 1'b0;
      memwb_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ctrl_state = state_q;

  sat_counter #(
    .Width (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (pc_stall),
    .count (perf_stall_cnt)
  );

  sat_counter #(
    .Width (CNT_W)
  ) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (idex_flush),
    .count (perf_flush_cnt)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table plus hand sequences for reset,
// redirect length and counter saturation.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, mem_req, mem_ready;

  logic        pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush;
  logic        exmem_stall, memwb_bubble;
  logic [1:0]  ctrl_state;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  logic        s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_stall, s_idex_flush;
  logic        s_exmem_stall, s_memwb_bubble;
  logic [1:0]  s_ctrl_state;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl u_dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd_addr     (ex_rd_addr),
    .ex_mem_read    (ex_mem_read),
    .ex_redirect    (ex_redirect),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_stall       (pc_stall),
    .ifid_stall     (ifid_stall),
    .ifid_flush     (ifid_flush),
    .idex_stall     (idex_stall),
    .idex_flush     (idex_flush),
    .exmem_stall    (exmem_stall),
    .memwb_bubble   (memwb_bubble),
    .ctrl_state     (ctrl_state),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  // Three-cycle redirects and 2-bit counters to exercise length and saturation.
  pipe_hazard_ctrl #(
    .FLUSH_CYCLES (3),
    .CNT_W        (2)
  ) u_small (
    .clk            (clk),
    .rst            (rst),
    .id_rs1_addr    (id_rs1_addr),
    .id_rs2_addr    (id_rs2_addr),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_rd_addr     (ex_rd_addr),
    .ex_mem_read    (ex_mem_read),
    .ex_redirect    (ex_redirect),
    .mem_req        (mem_req),
    .mem_ready      (mem_ready),
    .pc_stall       (s_pc_stall),
    .ifid_stall     (s_ifid_stall),
    .ifid_flush     (s_ifid_flush),
    .idex_stall     (s_idex_stall),
    .idex_flush     (s_idex_flush),
    .exmem_stall    (s_exmem_stall),
    .memwb_bubble   (s_memwb_bubble),
    .ctrl_state     (s_ctrl_state),
    .perf_stall_cnt (s_stall_cnt),
    .perf_flush_cnt (s_flush_cnt)
  );

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, mr, redir, req, rdy;
    logic [6:0] ctl;  // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble}
    logic [1:0] st;
  } vec_t;

  vec_t vecs[28];

  function automatic vec_t v(input logic [4:0] rs1, input logic [4:0] rs2, input logic use1,
                             input logic use2, input logic [4:0] rd, input logic mr,
                             input logic redir, input logic req, input logic rdy,
                             input logic [6:0] ctl, input logic [1:0] st);
    vec_t r;
    r.rs1 = rs1; r.rs2 = rs2; r.use1 = use1; r.use2 = use2; r.rd = rd; r.mr = mr;
    r.redir = redir; r.req = req; r.rdy = rdy; r.ctl = ctl; r.st = st;
    return r;
  endfunction

  function automatic logic [6:0] main_ctl();
    return {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
  endtask

  task automatic drive(input vec_t x);
    id_rs1_addr = x.rs1; id_rs2_addr = x.rs2; id_use_rs1 = x.use1; id_use_rs2 = x.use2;
    ex_rd_addr = x.rd; ex_mem_read = x.mr; ex_redirect = x.redir;
    mem_req = x.req; mem_ready = x.rdy;
  endtask

  vec_t idle;

  initial begin
    idle = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0, 2'd0);
    vecs[0]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    vecs[1]  = v(0, 5, 0, 1, 5, 1, 0, 0, 0, 7'b1100100, 2'd0);  // load-use on rs2
    vecs[2]  = v(0, 0, 0, 1, 0, 1, 0, 0, 0, 7'b0000000, 2'd0);  // rd = x0
    vecs[3]  = v(7, 0, 0, 0, 7, 1, 0, 0, 0, 7'b0000000, 2'd0);  // rs1 not used
    vecs[4]  = v(7, 0, 1, 0, 7, 1, 0, 0, 0, 7'b1100100, 2'd0);  // load-use on rs1
    vecs[5]  = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0010100, 2'd0);  // redirect
    vecs[6]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0010100, 2'd1);
    vecs[7]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    vecs[8]  = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1101011, 2'd0);  // memory wait x3
    vecs[9]  = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1101011, 2'd2);
    vecs[10] = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b1101011, 2'd2);
    vecs[11] = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0000000, 2'd2);
    vecs[12] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    vecs[13] = v(0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b1101011, 2'd0);  // redirect held in wait
    vecs[14] = v(0, 0, 0, 0, 0, 0, 1, 1, 0, 7'b1101011, 2'd2);
    vecs[15] = v(0, 0, 0, 0, 0, 0, 1, 1, 1, 7'b0010100, 2'd2);
    vecs[16] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0010100, 2'd1);
    vecs[17] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    vecs[18] = v(0, 5, 0, 1, 5, 1, 1, 0, 0, 7'b0010100, 2'd0);  // lu + redirect
    vecs[19] = v(0, 5, 0, 1, 5, 1, 1, 0, 0, 7'b0010100, 2'd1);
    vecs[20] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    vecs[21] = v(0, 0, 0, 0, 0, 0, 1, 0, 0, 7'b0010100, 2'd0);  // wait during flush
    vecs[22] = v(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0010111, 2'd1);
    vecs[23] = v(0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b0010100, 2'd1);
    vecs[24] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);
    vecs[25] = v(0, 5, 0, 1, 5, 1, 0, 1, 0, 7'b1101011, 2'd0);  // wait beats lu
    vecs[26] = v(0, 5, 0, 1, 5, 1, 0, 1, 1, 7'b1100100, 2'd2);
    vecs[27] = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b0000000, 2'd0);

    // Reset with a load-use pattern present: every control must stay low.
    rst = 1'b1;
    drive(vecs[1]);
    #2;
    chk("reset_ctl", 32'(main_ctl()), 32'd0);
    chk("reset_state", 32'(ctrl_state), 32'd0);
    chk("reset_stall_cnt", perf_stall_cnt, 32'd0);
    chk("reset_flush_cnt", perf_flush_cnt, 32'd0);
    @(negedge clk);
    drive(idle);
    rst = 1'b0;

    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      chk($sformatf("vec%0d_ctl", i), 32'(main_ctl()), 32'(vecs[i].ctl));
      chk($sformatf("vec%0d_state", i), 32'(ctrl_state), 32'(vecs[i].st));
    end
    chk("table_stall_cnt", perf_stall_cnt, 32'd9);
    chk("table_flush_cnt", perf_flush_cnt, 32'd12);

    // Asynchronous reset in the middle of FLUSH.
    @(negedge clk);
    ex_redirect = 1'b1;
    @(negedge clk);
    ex_redirect = 1'b0;
    #2;
    chk("pre_rst_flush_state", 32'(ctrl_state), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_flush_ctl", 32'(main_ctl()), 32'd0);
    chk("async_rst_flush_state", 32'(ctrl_state), 32'd0);
    chk("async_rst_flush_cnt", perf_flush_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("post_rst_no_flush", 32'(main_ctl()), 32'd0);
    chk("post_rst_state", 32'(ctrl_state), 32'd0);

    // Asynchronous reset in the middle of MEM_WAIT.
    @(negedge clk);
    mem_req = 1'b1;
    mem_ready = 1'b0;
    @(negedge clk);
    #2;
    chk("pre_rst_wait_state", 32'(ctrl_state), 32'd2);
    chk("pre_rst_wait_ctl", 32'(main_ctl()), 32'b1101011);
    rst = 1'b1;
    #1;
    chk("async_rst_wait_ctl", 32'(main_ctl()), 32'd0);
    chk("async_rst_wait_state", 32'(ctrl_state), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_req = 1'b0;
    #2;
    chk("post_rst_wait_state", 32'(ctrl_state), 32'd0);
    chk("post_rst_stall_cnt", perf_stall_cnt, 32'd0);

    // Single redirect pulse: 2 flush cycles on the default DUT, 3 on the small one.
    @(negedge clk);
    ex_redirect = 1'b1;
    #2;
    chk("small_flush_c0", 32'(s_idex_flush), 32'd1);
    @(negedge clk);
    ex_redirect = 1'b0;
    #2;
    chk("small_flush_c1", 32'({s_ifid_flush, s_idex_flush, s_ctrl_state}), 32'b1101);
    chk("main_flush_c1", 32'({ifid_flush, idex_flush, ctrl_state}), 32'b1101);
    @(negedge clk);
    #2;
    chk("small_flush_c2", 32'({s_ifid_flush, s_idex_flush, s_ctrl_state}), 32'b1101);
    chk("main_flush_done", 32'({ifid_flush, idex_flush, ctrl_state}), 32'b0000);
    @(negedge clk);
    #2;
    chk("small_flush_done", 32'({s_ifid_flush, s_idex_flush, s_ctrl_state}), 32'b0000);
    chk("small_flush_cnt_sat", 32'(s_flush_cnt), 32'd3);
    chk("main_flush_cnt_pulse", perf_flush_cnt, 32'd2);
    @(negedge clk);
    ex_redirect = 1'b1;
    @(negedge clk);
    ex_redirect = 1'b0;
    #2;
    chk("small_flush_cnt_hold", 32'(s_flush_cnt), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage scpu datapath. It generates stall, flush and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use hazards, control-flow redirects from EX, and multi-cycle data-memory waits. It replaces the per-register ad-hoc branch squash and counts stall and flush cycles for performance visibility.

Parameters:
FLUSH_CYCLES, 2, total consecutive cycles IF/ID and ID/EX are squashed per redirect (1..7)
CNT_W, 32, width of the saturating performance counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
id_rs1_addr  in  5  rs1 index of the instruction in ID
id_rs2_addr  in  5  rs2 index of the instruction in ID
id_use_rs1  in  1  ID instruction reads rs1
id_use_rs2  in  1  ID instruction reads rs2
ex_rd_addr  in  5  rd of the instruction in EX (ID/EX output)
ex_mem_read  in  1  EX instruction is a load
ex_redirect  in  1  EX resolved a taken branch or jump
mem_req  in  1  MEM stage issues a data-memory access
mem_ready  in  1  data memory completes the access this cycle
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
ifid_flush  out  1  load NOP (32'h00000013) into IF/ID
idex_stall  out  1  hold ID/EX
idex_flush  out  1  load bubble (all controls 0, inst 32'h00000013) into ID/EX
exmem_stall  out  1  hold EX/MEM
memwb_bubble  out  1  load bubble into MEM/WB
ctrl_state  out  2  current FSM state encoding
perf_stall_cnt  out  CNT_W  cycles with pc_stall=1
perf_flush_cnt  out  CNT_W  cycles with idex_flush=1

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk. Control outputs are combinational from state and inputs. Counters and state are registered.
- Reset: state=RUN, flush counter=0, perf counters=0. All control outputs are 0 while rst=1.
- Load-use hazard: lu = ex_mem_read & ex_rd_addr!=0 & ((id_use_rs1 & ex_rd_addr==id_rs1_addr) | (id_use_rs2 & ex_rd_addr==id_rs2_addr)). It is only evaluated in state RUN.
  - When lu=1: pc_stall=1, ifid_stall=1, idex_flush=1.
  - The bubble removes the load from EX, so the stall lasts exactly 1 cycle. No extra state is needed.
- States: RUN=0, FLUSH=1, MEM_WAIT=2. Encoding 3 is unreachable and decodes to RUN.
- Priority within a cycle: memory wait > redirect > load-use.
- RUN:
  - mem_req & !mem_ready: assert pc_stall, ifid_stall, idex_stall, exmem_stall and memwb_bubble. Next state MEM_WAIT. Redirect and lu are ignored.
  - Else if ex_redirect: assert ifid_flush=1 and idex_flush=1, stall outputs 0. If FLUSH_CYCLES>1, load cnt=FLUSH_CYCLES-1 and go to FLUSH; otherwise stay in RUN.
  - Else if lu: load-use response as above.
- FLUSH:
  - ifid_flush=1, idex_flush=1. Decrement cnt; return to RUN when cnt reaches 0.
  - A new ex_redirect in FLUSH cannot occur, because EX holds a bubble. If asserted anyway, it is ignored.
  - mem_req & !mem_ready in FLUSH: stall EX/MEM and below as in MEM_WAIT, and freeze cnt. Flushes continue.
- MEM_WAIT:
  - Hold the same outputs as the RUN memory-wait case every cycle until mem_ready=1.
  - In the cycle mem_ready=1, all stalls drop. ex_redirect and lu are then evaluated with RUN rules in that same cycle, and the next state is chosen by them.
  - ex_redirect persists through the wait because ID/EX is held, so each redirect is applied exactly once.
- Simultaneous lu and ex_redirect: redirect wins. The flush discards the dependent instruction.
- perf counters: increment on pc_stall / idex_flush respectively and saturate at all-ones, with no wrap.
- Reset asserted mid-FLUSH or mid-MEM_WAIT: immediately return to RUN with all controls 0. No pending redirect survives.

Decomposition:
- Shared package (scpu_pkg) holds:
  - state enum RUN/FLUSH/MEM_WAIT
  - NOP_INST = 32'h00000013
  - x0 index constant 5'd0
- One natural sub-module, sat_counter (width parameter, inc, rst), instantiated twice for the perf counters.
- Hazard compare stays inline.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd_addr=5, id_rs2_addr=5, id_use_rs2=1 -> one cycle with pc_stall=ifid_stall=idex_flush=1; perf_stall_cnt=1. With ex_rd_addr=0 -> no stall.
- Redirect: ex_redirect pulse in RUN -> ifid_flush=idex_flush=1 for exactly 2 cycles (FLUSH_CYCLES=2), ctrl_state 0->1->0; perf_flush_cnt=2.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> stalls and memwb_bubble high for 3 cycles, drop on ready cycle; perf_stall_cnt=3.
- Redirect during wait: ex_redirect=1 held with mem_ready low for 2 cycles -> no flush while waiting; flush begins in the ready cycle and lasts 2 cycles total.
- lu and redirect together: both asserted in RUN -> flush only, pc_stall=0.
- Async reset in FLUSH and in MEM_WAIT -> outputs 0 without waiting for a clock edge; ctrl_state=0 and counters=0 after release.
